// File: rtl/rdma_descriptor_arbiter.sv
// Round-robin arbiter that serializes one {src, dst, len} descriptor at a time
// onto the RDMA metadata AXI-stream, MSB-first, with a credit limit on in-flight descriptors.
module rdma_descriptor_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int AXI_FRAME_SIZE   = 32,
    parameter int SRC_ADDRESS_SIZE = 48,
    parameter int DST_ADDRESS_SIZE = 48,
    parameter int MEM_LENGTH       = 32,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*SRC_ADDRESS_SIZE-1:0]    req_src,
    input  logic [NUM_REQ*DST_ADDRESS_SIZE-1:0]    req_dst,
    input  logic [NUM_REQ*MEM_LENGTH-1:0]          req_len,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [AXI_FRAME_SIZE-1:0]              m_axis_tdata,
    output logic                                   m_axis_tlast,
    output logic [$clog2(NUM_REQ)-1:0]             m_axis_tuser,
    input  logic                                   meta_done,
    output logic [3:0]                             outstanding,
    output logic                                   busy
);

    localparam int IW        = $clog2(NUM_REQ);
    localparam int BW        = 8;
    localparam int SRC_BEATS = (SRC_ADDRESS_SIZE + AXI_FRAME_SIZE - 1) / AXI_FRAME_SIZE;
    localparam int DST_BEATS = (DST_ADDRESS_SIZE + AXI_FRAME_SIZE - 1) / AXI_FRAME_SIZE;
    localparam int LEN_BEATS = (MEM_LENGTH + AXI_FRAME_SIZE - 1) / AXI_FRAME_SIZE;
    localparam int MW0       = (SRC_ADDRESS_SIZE > DST_ADDRESS_SIZE) ? SRC_ADDRESS_SIZE : DST_ADDRESS_SIZE;
    localparam int MW1       = (MW0 > MEM_LENGTH) ? MW0 : MEM_LENGTH;
    localparam int FW        = (MW1 > AXI_FRAME_SIZE) ? MW1 : AXI_FRAME_SIZE;

    typedef enum logic [1:0] {IDLE, SEND_SRC, SEND_DST, SEND_LEN} state_e;

    state_e                      state_q;
    logic [IW-1:0]               rr_ptr_q;
    logic [IW-1:0]               gnt_q;
    logic [BW-1:0]               beat_q;
    logic [SRC_ADDRESS_SIZE-1:0] src_q;
    logic [DST_ADDRESS_SIZE-1:0] dst_q;
    logic [MEM_LENGTH-1:0]       len_q;
    logic [3:0]                  outstanding_q;
    logic [3:0]                  outstanding_d;

    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] next_ptr;
    logic          gnt_found;
    logic          grant;
    logic          beat_accept;
    logic          field_last;
    logic          credit_inc;
    logic          credit_dec;

    // Chunk 'beat' of a right-aligned field: MSB-first, final partial chunk right-justified.
    function automatic logic [AXI_FRAME_SIZE-1:0] chunk_f(input logic [FW-1:0] field,
                                                          input int width, input int beat);
        int            rem;
        logic [FW-1:0] sel;
        rem = width - beat * AXI_FRAME_SIZE;
        if (rem >= AXI_FRAME_SIZE)
            sel = field >> (rem - AXI_FRAME_SIZE);
        else if (rem > 0)
            sel = field & ({FW{1'b1}} >> (FW - rem));
        else
            sel = '0;
        return sel[AXI_FRAME_SIZE-1:0];
    endfunction

    always_comb begin
        logic [IW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        next_ptr = IW'((int'(gnt_idx) + 1) % NUM_REQ);
        // Gated by rst_n so req_ready is also forced low while reset is held.
        grant     = rst_n && (state_q == IDLE) && gnt_found &&
                    (outstanding_q < 4'(MAX_OUTSTANDING));
        req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        field_last   = 1'b0;
        m_axis_tdata = '0;
        case (state_q)
            SEND_SRC: begin
                field_last   = (beat_q == BW'(SRC_BEATS - 1));
                m_axis_tdata = chunk_f(FW'(src_q), SRC_ADDRESS_SIZE, int'(beat_q));
            end
            SEND_DST: begin
                field_last   = (beat_q == BW'(DST_BEATS - 1));
                m_axis_tdata = chunk_f(FW'(dst_q), DST_ADDRESS_SIZE, int'(beat_q));
            end
            SEND_LEN: begin
                field_last   = (beat_q == BW'(LEN_BEATS - 1));
                m_axis_tdata = chunk_f(FW'(len_q), MEM_LENGTH, int'(beat_q));
            end
            default: ;
        endcase
    end

    assign m_axis_tvalid = (state_q != IDLE);
    assign m_axis_tlast  = (state_q == SEND_LEN) && field_last;
    assign m_axis_tuser  = gnt_q;
    assign busy          = (state_q != IDLE);
    assign outstanding   = outstanding_q;
    assign beat_accept   = m_axis_tvalid && m_axis_tready;

    // A meta_done with nothing in flight is dropped; inc and dec together cancel.
    always_comb begin
        credit_inc    = beat_accept && m_axis_tlast;
        credit_dec    = meta_done && (outstanding_q != 4'd0);
        outstanding_d = outstanding_q;
        if (credit_inc && !credit_dec)
            outstanding_d = outstanding_q + 4'd1;
        else if (credit_dec && !credit_inc)
            outstanding_d = outstanding_q - 4'd1;
    end

    // NOTE: holding registers are reset too, so tdata/tuser read 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            beat_q        <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            outstanding_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            outstanding_q <= outstanding_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        src_q    <= req_src[gnt_idx*SRC_ADDRESS_SIZE +: SRC_ADDRESS_SIZE];
                        dst_q    <= req_dst[gnt_idx*DST_ADDRESS_SIZE +: DST_ADDRESS_SIZE];
                        len_q    <= req_len[gnt_idx*MEM_LENGTH +: MEM_LENGTH];
                        gnt_q    <= gnt_idx;
                        rr_ptr_q <= next_ptr;
                        beat_q   <= '0;
                        state_q  <= SEND_SRC;
                    end
                end
                SEND_SRC: begin
                    if (beat_accept) begin
                        if (field_last) begin
                            beat_q  <= '0;
                            state_q <= SEND_DST;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                SEND_DST: begin
                    if (beat_accept) begin
                        if (field_last) begin
                            beat_q  <= '0;
                            state_q <= SEND_LEN;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                SEND_LEN: begin
                    if (beat_accept) begin
                        if (field_last) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rdma_descriptor_arbiter.md
Name: rdma_descriptor_arbiter

Overview:
- Shares the single RDMA metadata AXI-stream ingress between NUM_REQ descriptor requesters. Each requester supplies a {src address, dst address, length} descriptor.
- Round-robin arbitration picks one requester at a time. The granted descriptor is serialized MSB-first into AXI_FRAME_SIZE-wide beats in the order SRC, DST, LEN, which is the field order and chunking the metadata resolver reassembles.
- A credit counter limits how many descriptors may be in flight before the resolver acknowledges them.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AXI_FRAME_SIZE, 32, stream data width in bits.
- SRC_ADDRESS_SIZE, 48, source address width.
- DST_ADDRESS_SIZE, 48, destination address width.
- MEM_LENGTH, 32, transfer length width.
- MAX_OUTSTANDING, 2, maximum number of descriptors sent but not yet acknowledged (1..15).

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester descriptor valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot pulse.
- req_src  in  NUM_REQ*SRC_ADDRESS_SIZE  packed source addresses; requester i at slice i.
- req_dst  in  NUM_REQ*DST_ADDRESS_SIZE  packed destination addresses.
- req_len  in  NUM_REQ*MEM_LENGTH  packed lengths.
- m_axis_tvalid  out  1  stream beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXI_FRAME_SIZE  beat payload.
- m_axis_tlast  out  1  final beat of a descriptor.
- m_axis_tuser  out  $clog2(NUM_REQ)  index of the granted requester.
- meta_done  in  1  single-cycle pulse from the resolver: one descriptor consumed.
- outstanding  out  4  current in-flight descriptor count.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; all outputs 0; outstanding=0.
  - RR pointer set so requester 0 has highest priority.
  - A reset mid-transfer drops tvalid immediately; the partial descriptor is discarded without completing its beats.
- States: IDLE, SEND_SRC, SEND_DST, SEND_LEN.
- IDLE arbitration:
  - If any req_valid is high and outstanding<MAX_OUTSTANDING, grant the first valid requester at or after the RR pointer, searching with wrap-around.
  - In that same cycle, req_ready[g] pulses for 1 cycle and the descriptor plus g are latched into holding registers.
  - RR pointer becomes g+1 mod NUM_REQ. State becomes SEND_SRC.
  - Requester inputs may change after the req_ready pulse.
- Latency: grant in cycle T means first tvalid in cycle T+1. After the last beat is accepted the block returns to IDLE, so the earliest next grant is the following cycle.
- Beat counts per field: ceil(W/AXI_FRAME_SIZE), where W is the field width. With the default parameters: SRC=2, DST=2, LEN=1, for 5 beats per descriptor.
- Chunking rule for each field:
  - Each beat carries min(remaining, AXI_FRAME_SIZE) bits, taken from the MSB end of the not-yet-sent bits.
  - The chunk is right-justified in tdata; unused upper bits are 0.
  - Example, 48-bit field: beat0 = field[47:16], beat1 = {16'h0, field[15:0]}.
- Handshake:
  - A beat transfers on tvalid&&tready.
  - While tvalid=1 and tready=0, tdata, tlast and tuser hold stable.
  - tvalid never drops before acceptance.
- Sequencing:
  - The state advances after the final beat of its field is accepted: SEND_SRC to SEND_DST to SEND_LEN.
  - On acceptance of the tlast beat, the state returns to IDLE.
- tlast is high only on the final beat of SEND_LEN. tuser equals the latched g on every beat of the descriptor.
- Credit counter:
  - +1 on acceptance of the tlast beat; −1 on meta_done.
  - Both in the same cycle: no change.
  - meta_done while outstanding=0 is ignored; the counter never underflows.
  - A grant is blocked while outstanding==MAX_OUTSTANDING; req_ready stays 0.
- A length field of zero is sent unchanged; the block does not interpret it.
- req_valid deasserting before it is granted is legal; no grant is issued to that requester.
- Address and length fields are opaque data; the block performs no arithmetic on them.

Test Plan:
- Single request, default parameters: req0 src=48'hA1A2_B3B4_C5C6, dst=48'h1111_2222_3333, len=32'h0000_1000. Expected: 5 beats in order 32'hA1A2B3B4, 32'h0000C5C6, 32'h11112222, 32'h00003333, 32'h00001000; tlast only on beat 5; tuser=0 on all beats; outstanding=1.
- Round-robin fairness: all 4 req_valid held high and meta_done pulsed after each descriptor. Expected grant order 0,1,2,3,0; each req_ready pulse lasts exactly 1 cycle.
- Backpressure: tready=0 for 3 cycles on beat 2. Expected: tdata/tlast/tuser stable throughout and no beat duplicated or lost.
- Credit limit, MAX_OUTSTANDING=2, no meta_done: the third descriptor is not granted (req_ready=0, busy=0). One meta_done pulse causes a grant on the next IDLE cycle. A simultaneous meta_done and tlast acceptance leaves outstanding unchanged.
- Spurious meta_done at outstanding=0: outstanding stays 0.
- Reset mid-beat: assert rst_n=0 during SEND_DST. Expected: tvalid=0 and outputs 0 asynchronously; after release, req0 wins arbitration first.
